cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_cache_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: 16-set, 2-way, write-through cache controller.
// Holds the tag/valid/LRU state and sequences main-memory traffic. The data
// array itself lives outside this block and is steered via arr_* outputs.
module cache_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [2:0]            cpu_addr_mode,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic [3:0]            arr_set,
    output logic                  arr_way,
    output logic                  arr_we,
    output logic                  arr_fill,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
);

    localparam int TAG_W = ADDR_WIDTH - 6;
    // Full-word access code; every other code is a sub-word (byte) access.
    localparam logic [2:0] MODE_WORD = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  hit_q, hit_d;         // latched: request hit in the cache
    logic                  way_q, way_d;         // latched: hit way or victim way
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]           hit_cnt_q, hit_cnt_d;
    logic [15:0]           miss_cnt_q, miss_cnt_d;

    logic [1:0]            valid_q [16];
    logic [15:0]           lru_q;                // per set: way to evict next
    logic [TAG_W-1:0]      tag_q [16][2];

    logic [3:0]            set_idx;
    logic [TAG_W-1:0]      addr_tag;
    logic                  hit0, hit1, hit_any, hit_way, victim, word_mode, ack;
    logic                  tag_we, lru_we, lru_val, stall_c;
    logic                  arr_way_c, arr_we_c, arr_fill_c;
    logic                  unused_wdata;

    assign set_idx   = cpu_addr[5:2];
    assign addr_tag  = cpu_addr[ADDR_WIDTH-1:6];
    assign hit0      = valid_q[set_idx][0] && (tag_q[set_idx][0] == addr_tag);
    assign hit1      = valid_q[set_idx][1] && (tag_q[set_idx][1] == addr_tag);
    assign hit_any   = hit0 | hit1;
    assign hit_way   = !hit0;                    // way 0 wins if both match
    assign victim    = !valid_q[set_idx][0] ? 1'b0 :
                       !valid_q[set_idx][1] ? 1'b1 : lru_q[set_idx];
    assign word_mode = (cpu_addr_mode == MODE_WORD);
    assign ack       = mem_req_q && mem_ack;     // ack only meaningful while requesting
    // Store data goes straight to the data array; the controller never looks at it.
    assign unused_wdata = ^cpu_wdata;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next-state, memory handshake, counters and array steering.
    always_comb begin
        state_d    = state_q;
        hit_d      = hit_q;
        way_d      = way_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        stall_c    = 1'b0;
        arr_way_c  = way_q;
        arr_we_c   = 1'b0;
        arr_fill_c = 1'b0;
        tag_we     = 1'b0;
        lru_we     = 1'b0;
        lru_val    = !way_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    if (!cpu_we && hit_any) begin
                        arr_way_c = hit_way;
                        lru_we    = 1'b1;
                        lru_val   = !hit_way;
                        hit_cnt_d = sat_inc(hit_cnt_q);
                    end else begin
                        stall_c    = 1'b1;
                        hit_d      = hit_any;
                        way_d      = hit_any ? hit_way : victim;
                        hit_cnt_d  = hit_any ? sat_inc(hit_cnt_q) : hit_cnt_q;
                        miss_cnt_d = hit_any ? miss_cnt_q : sat_inc(miss_cnt_q);
                        mem_req_d  = 1'b1;
                        mem_we_d   = cpu_we;
                        mem_addr_d = cpu_we ? cpu_addr : {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        state_d    = cpu_we ? S_WRITE : S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                stall_c = 1'b1;
                if (ack) begin
                    arr_we_c   = 1'b1;
                    arr_fill_c = 1'b1;
                    tag_we     = 1'b1;
                    lru_we     = 1'b1;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_WRITE: begin
                stall_c = 1'b1;
                if (ack) begin
                    // Hit updates the line; word miss allocates; byte miss bypasses.
                    if (hit_q) begin
                        arr_we_c = 1'b1;
                        lru_we   = 1'b1;
                    end else if (word_mode) begin
                        arr_we_c = 1'b1;
                        tag_we   = 1'b1;
                        lru_we   = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers, valid bits and LRU bits; async clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hit_q      <= 1'b0;
            way_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            lru_q      <= '0;
            for (int i = 0; i < 16; i++) begin
                valid_q[i] <= 2'b00;
            end
        end else begin
            state_q    <= state_d;
            hit_q      <= hit_d;
            way_q      <= way_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if (tag_we) begin
                valid_q[set_idx][way_q] <= 1'b1;
            end
            if (lru_we) begin
                lru_q[set_idx] <= lru_val;
            end
        end
    end

    // Tag storage needs no reset: entries are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[set_idx][way_q] <= addr_tag;
        end
    end

    assign cpu_stall = stall_c & rst_n;
    assign arr_set   = set_idx;
    assign arr_way   = arr_way_c;
    assign arr_we    = arr_we_c;
    assign arr_fill  = arr_fill_c;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: stimulus pushes expected memory requests,
// array writes and completions; a negedge monitor pops and compares them.
module tb_cache_ctrl;

    localparam logic [2:0] MODE_BYTE = 3'b000;
    localparam logic [2:0] MODE_WORD = 3'b010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_addr_mode;
    logic        cpu_stall, arr_way, arr_we, arr_fill, mem_req, mem_we, mem_ack;
    logic [3:0]  arr_set;
    logic [31:0] mem_addr;
    logic [15:0] hit_cnt, miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] mem_q [$];   // {we, addr}
    logic [5:0]  arr_q [$];   // {way, fill, set}
    logic [1:0]  cpl_q [$];   // {check_way, way}
    logic [32:0] mem_e;
    logic [5:0]  arr_e;
    logic [1:0]  cpl_e;
    logic        mem_req_prev = 1'b0;
    logic        ack_en = 1'b1;
    int          ack_delay = 3;

    cache_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_addr_mode(cpu_addr_mode), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .arr_set(arr_set), .arr_way(arr_way), .arr_we(arr_we),
        .arr_fill(arr_fill), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: acknowledges a request ack_delay cycles after it appears.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req && ack_en) begin
                for (int k = 1; k < ack_delay; k++) @(posedge clk);
                #2;
                if (mem_req && ack_en) mem_ack = 1'b1;
                @(posedge clk);
                #2 mem_ack = 1'b0;
            end
        end
    end

    // Monitor: compares every observed DUT event against the scoreboard queues.
    always @(negedge clk) begin
        if (arr_we) begin
            check("arr_we_only_on_ack", mem_ack, 1'b1);
            if (arr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL arr_unexpected: got write way=%0d set=%0d expected none", arr_way, arr_set);
            end else begin
                arr_e = arr_q.pop_front();
                check("arr_write", {arr_way, arr_fill, arr_set}, arr_e);
            end
        end
        if (rst_n && mem_req && !mem_req_prev) begin
            if (mem_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mem_unexpected: got addr 0x%0h expected none", mem_addr);
            end else begin
                mem_e = mem_q.pop_front();
                check("mem_request", {mem_we, mem_addr}, mem_e);
            end
        end
        mem_req_prev = mem_req;
        if (rst_n && cpu_req && !cpu_stall) begin
            if (cpl_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL cpl_unexpected: got completion addr 0x%0h expected none", cpu_addr);
            end else begin
                cpl_e = cpl_q.pop_front();
                if (cpl_e[1]) check("cpl_arr_way", arr_way, cpl_e[0]);
            end
        end
    end

    // One CPU access; expectations are queued before the request is driven.
    task automatic access(input logic we, input logic [31:0] addr, input logic [2:0] mode,
                          input logic [31:0] wd, input logic exp_mem, input logic [31:0] exp_maddr,
                          input logic exp_arr, input logic exp_way, input logic exp_fill,
                          input logic chk_way, input logic [15:0] exp_h, input logic [15:0] exp_m);
        int  n;
        logic done;
        logic [3:0] set_e;
        set_e = addr[5:2];
        if (exp_mem) mem_q.push_back({we, exp_maddr});
        if (exp_arr) arr_q.push_back({exp_way, exp_fill, set_e});
        cpl_q.push_back({chk_way, exp_way});
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_addr_mode = mode; cpu_wdata = wd;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
            else begin
                n++;
                if (n >= 100) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stall_timeout: got stall for %0d cycles expected release", n);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1 cpu_req = 1'b0;
        check("hit_cnt", hit_cnt, exp_h);
        check("miss_cnt", miss_cnt, exp_m);
        $display("[TB] %s addr=0x%08h cycles=%0d hit_cnt=%0d miss_cnt=%0d",
                 we ? "store" : "load ", addr, n + 1, hit_cnt, miss_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a pending miss on the bus: no stall and no requests allowed.
        rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        cpu_addr_mode = MODE_WORD; cpu_wdata = '0;
        #12;
        check("rst_cpu_stall", cpu_stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_arr_we", arr_we, 1'b0);
        check("rst_arr_fill", arr_fill, 1'b0);
        check("rst_hit_cnt", hit_cnt, 16'h0);
        check("rst_miss_cnt", miss_cnt, 16'h0);
        cpu_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_no_stall", cpu_stall, 1'b0);

        //     we    addr          mode       wdata         mem   maddr         arr   way   fill  chk   hit     miss
        access(1'b0, 32'h0000_0040, MODE_WORD, 32'h0,        1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1);
        access(1'b0, 32'h0000_0040, MODE_WORD, 32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1);
        ack_delay = 1;
        access(1'b0, 32'h0000_0080, MODE_WORD, 32'h0,        1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 16'd2);
        access(1'b1, 32'h0000_0040, MODE_WORD, 32'hDEADBEEF, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 16'd2);
        access(1'b0, 32'h0000_0080, MODE_WORD, 32'h0,        1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 16'd2);
        ack_delay = 3;
        access(1'b0, 32'h0000_00C0, MODE_WORD, 32'h0,        1'b1, 32'h0000_00C0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3, 16'd3);
        access(1'b0, 32'h0000_0040, MODE_WORD, 32'h0,        1'b1, 32'h0000_0040, 1'b1, 1'b1, 1'b1, 1'b1, 16'd3, 16'd4);
        access(1'b0, 32'h0000_00C0, MODE_WORD, 32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 16'd4);
        access(1'b1, 32'h0000_0104, MODE_BYTE, 32'h0000_00A5, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 16'd5);
        ack_delay = 2;
        access(1'b0, 32'h0000_0104, MODE_WORD, 32'h0,        1'b1, 32'h0000_0104, 1'b1, 1'b0, 1'b1, 1'b1, 16'd4, 16'd6);
        access(1'b1, 32'h0000_0204, MODE_WORD, 32'h1234_5678, 1'b1, 32'h0000_0204, 1'b1, 1'b1, 1'b0, 1'b1, 16'd4, 16'd7);
        access(1'b0, 32'h0000_0204, MODE_WORD, 32'h0,        1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 16'd7);
        access(1'b0, 32'h0000_0307, MODE_WORD, 32'h0,        1'b1, 32'h0000_0304, 1'b1, 1'b0, 1'b1, 1'b1, 16'd5, 16'd8);
        ack_delay = 3;

        // Abort a refill with reset two cycles in: nothing may be written.
        begin
            int n;
            ack_en = 1'b0;
            mem_q.push_back({1'b0, 32'h0000_0500});
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500; cpu_addr_mode = MODE_WORD;
            n = 0;
            while (!mem_req && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("abort_refill_entered", mem_req, 1'b1);
            @(posedge clk); @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            check("abort_mem_req", mem_req, 1'b0);
            check("abort_mem_we", mem_we, 1'b0);
            check("abort_cpu_stall", cpu_stall, 1'b0);
            check("abort_arr_we", arr_we, 1'b0);
            cpu_req = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1; ack_en = 1'b1;
            check("abort_hit_cnt", hit_cnt, 16'h0);
            check("abort_miss_cnt", miss_cnt, 16'h0);
            $display("[TB] reset abort during refill addr=0x00000500");
        end
        @(posedge clk); #1;
        // Valid bits cleared: previously cached set 0 misses into way 0.
        access(1'b0, 32'h0000_0500, MODE_WORD, 32'h0, 1'b1, 32'h0000_0500, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1);

        // Back-to-back zero-wait hits drive hit_cnt to its ceiling.
        for (int i = 0; i < 65535; i++) cpl_q.push_back(2'b10);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500; cpu_addr_mode = MODE_WORD;
        repeat (65535) @(posedge clk);
        #1 cpu_req = 1'b0;
        check("burst_hit_cnt", hit_cnt, 16'hFFFF);
        check("burst_miss_cnt", miss_cnt, 16'd1);
        $display("[TB] hit burst x65535 addr=0x00000500 hit_cnt=%0d miss_cnt=%0d", hit_cnt, miss_cnt);
        access(1'b0, 32'h0000_0500, MODE_WORD, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'd1);

        repeat (3) @(posedge clk);
        #1;
        check("mem_q_drained", mem_q.size(), 0);
        check("arr_q_drained", arr_q.size(), 0);
        check("cpl_q_drained", cpl_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
